isz_dr_seq: RTL

//  Sequencer for the DR data path of the basic computer. Runs the read-modify-write ISZ

---
 rtl/isz_dr_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/isz_dr_seq.sv
// ISZ read-modify-write sequencer for the basic computer DR path:
// fetch M[addr] into DR, increment, write back, report skip-if-zero.
module isz_dr_seq #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          CLK,
    input  logic          CLR_n,
    input  logic          start,
    input  logic [AW-1:0] addr,
    output logic          busy,
    output logic          done,
    output logic          skip,
    output logic          err,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          dr_ld,
    output logic          dr_inr,
    output logic [DW-1:0] dr_in,
    input  logic [DW-1:0] dr_q
);

    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LOAD = 3'd2,
        S_INCR = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_rdata;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            w_timeout;

    // Last cycle of a strobe that has waited MAX_WAIT cycles without ack
    assign w_timeout = (r_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= addr;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_state <= S_LOAD;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LOAD: r_state <= S_INCR;
                S_INCR: begin
                    r_cnt   <= '0;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (mem_ack) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the state register so reset clears strobes asynchronously
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = done && r_err;
    assign skip      = done && !r_err && (dr_q == '0);
    assign mem_rd    = (r_state == S_RD);
    assign mem_wr    = (r_state == S_WR);
    assign mem_addr  = r_addr;
    assign mem_wdata = (r_state == S_WR) ? dr_q : '0;
    assign dr_ld     = (r_state == S_LOAD);
    assign dr_inr    = (r_state == S_INCR);
    assign dr_in     = r_rdata;

endmodule
